// File: rtl/frac_lut6_cfg_loader_pkg.sv
// Shared constants and types for the fracturable LUT6 configuration loader.
// Frame layout: bits 0..63 form the truth table, bit 64 is mode[0] and
// bit 65 is mode[1].
package frac_lut_cfg_pkg;

   localparam int SRAM_BITS  = 64;
   localparam int MODE_BITS  = 2;
   localparam int FRAME_BITS = SRAM_BITS + MODE_BITS;
   localparam int IDX_W      = 7;
   localparam int MODE0_IDX  = 64;
   localparam int MODE1_IDX  = 65;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT,
      ST_READ,
      ST_ERR
   } cfg_state_t;

endpackage

// File: rtl/frac_lut6_cfg_loader_if.sv
// Programming-chain interface of the LUT6 configuration loader.
// master: programming chain (drives frame bits and requests).
// slave : loader (drives ready/done/err and the readback stream).
interface frac_lut6_cfg_loader_if;

   logic cfg_start;
   logic cfg_valid;
   logic cfg_bit;
   logic cfg_last;
   logic cfg_ready;
   logic cfg_done;
   logic cfg_err;
   logic rb_req;
   logic rb_valid;
   logic rb_bit;

   modport master (
      output cfg_start, cfg_valid, cfg_bit, cfg_last, rb_req,
      input  cfg_ready, cfg_done, cfg_err, rb_valid, rb_bit
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, cfg_last, rb_req,
      output cfg_ready, cfg_done, cfg_err, rb_valid, rb_bit
   );

endinterface

// File: rtl/frac_lut6_cfg_loader_shadow.sv
// cfg_frame_shadow: shadow register for an in-flight frame plus the
// committed frame copy.
// Ports: prog_clk/prog_rst_n clock and async active-low reset; wr_en/wr_idx/
// wr_bit indexed shadow write; commit copies the shadow (including a bit
// written in the same cycle) into frame_q, the committed configuration.
module cfg_frame_shadow
   import frac_lut_cfg_pkg::*;
(
   input  logic                  prog_clk,
   input  logic                  prog_rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic                  wr_bit,
   input  logic                  commit,
   output logic [FRAME_BITS-1:0] frame_q
);

   logic [FRAME_BITS-1:0] shadow_q;
   logic [FRAME_BITS-1:0] shadow_d;

   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) shadow_d[wr_idx] = wr_bit;
   end

   // The commit copy takes shadow_d so the final frame bit, accepted on the
   // same edge, lands in the committed frame without an extra cycle.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         shadow_q <= '0;
         frame_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         if (commit) frame_q <= shadow_d;
      end
   end

endmodule

// File: rtl/frac_lut6_cfg_loader.sv
// frac_lut6_cfg_loader: bit-serial configuration writer and readback for one
// fracturable LUT6.
// Ports: prog_clk, prog_rst_n (async active-low); cfg (slave modport of
// frac_lut6_cfg_loader_if) carrying the frame handshake and readback stream;
// sram/sram_inv and mode/mode_inv driving the LUT configuration inputs.
//
// state     | meaning
// ST_IDLE   | waiting for cfg_start or rb_req
// ST_SHIFT  | accepting frame bits into the shadow, idx = next bit
// ST_COMMIT | one-cycle commit, cfg_done high
// ST_READ   | streaming committed bit idx on rb_bit
// ST_ERR    | framing error, cfg_err held until cfg_start
module frac_lut6_cfg_loader
   import frac_lut_cfg_pkg::*;
(
   input  logic                   prog_clk,
   input  logic                   prog_rst_n,
   frac_lut6_cfg_loader_if.slave  cfg,
   output logic [SRAM_BITS-1:0]   sram,
   output logic [SRAM_BITS-1:0]   sram_inv,
   output logic [MODE_BITS-1:0]   mode,
   output logic [MODE_BITS-1:0]   mode_inv
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MODE1_IDX);

   cfg_state_t            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  accept;
   logic                  commit;
   logic [FRAME_BITS-1:0] frame_q;

   // cfg_ready is registered as "state is SHIFT", so it equals that here.
   assign accept = (state_q == ST_SHIFT) && cfg.cfg_valid && !cfg.cfg_start;
   assign commit = accept && cfg.cfg_last && (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg.cfg_start) begin
               state_d = ST_SHIFT;
               idx_d   = '0;
            end else if (cfg.rb_req) begin
               state_d = ST_READ;
               idx_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (cfg.cfg_start) begin
               idx_d = '0;
            end else if (cfg.cfg_valid) begin
               if (cfg.cfg_last) begin
                  state_d = (idx_q == LAST_IDX) ? ST_COMMIT : ST_ERR;
                  idx_d   = '0;
               end else if (idx_q == LAST_IDX) begin
                  state_d = ST_ERR;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         ST_READ: begin
            if (cfg.cfg_start) begin
               state_d = ST_SHIFT;
               idx_d   = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 7'd1;
            end
         end
         ST_ERR: begin
            if (cfg.cfg_start) begin
               state_d = ST_SHIFT;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cfg.cfg_ready <= 1'b0;
         cfg.cfg_done  <= 1'b0;
         cfg.cfg_err   <= 1'b0;
         cfg.rb_valid  <= 1'b0;
         cfg.rb_bit    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cfg.cfg_ready <= (state_d == ST_SHIFT);
         cfg.cfg_done  <= (state_d == ST_COMMIT);
         cfg.rb_valid  <= (state_d == ST_READ);
         cfg.rb_bit    <= (state_d == ST_READ) ? frame_q[idx_d] : 1'b0;
         if (cfg.cfg_start)         cfg.cfg_err <= 1'b0;
         else if (state_d == ST_ERR) cfg.cfg_err <= 1'b1;
      end
   end

   cfg_frame_shadow u_shadow (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .wr_en      (accept),
      .wr_idx     (idx_q),
      .wr_bit     (cfg.cfg_bit),
      .commit     (commit),
      .frame_q    (frame_q)
   );

   assign sram     = frame_q[SRAM_BITS-1:0];
   assign mode     = frame_q[MODE1_IDX:MODE0_IDX];
   assign sram_inv = ~sram;
   assign mode_inv = ~mode;

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Self-checking bench for frac_lut6_cfg_loader. The reference model is the
// committed frame as a plain 66-bit value, updated only when a well-formed
// frame completes.
module tb_frac_lut6_cfg_loader;

   logic        prog_clk;
   logic        prog_rst_n;
   logic [63:0] sram, sram_inv;
   logic [1:0]  mode, mode_inv;

   int checks = 0;
   int errors = 0;

   logic [65:0] ref_frame;

   frac_lut6_cfg_loader_if cfg_if ();

   frac_lut6_cfg_loader dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .cfg        (cfg_if),
      .sram       (sram),
      .sram_inv   (sram_inv),
      .mode       (mode),
      .mode_inv   (mode_inv)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_lut(input string tag);
      chk({tag, "_sram"}, {2'b00, sram}, {2'b00, ref_frame[63:0]});
      chk({tag, "_sram_inv"}, {2'b00, sram_inv}, {2'b00, ~ref_frame[63:0]});
      chk({tag, "_mode"}, {64'd0, mode}, {64'd0, ref_frame[65:64]});
      chk({tag, "_mode_inv"}, {64'd0, mode_inv}, {64'd0, ~ref_frame[65:64]});
   endtask

   // Pulses cfg_start (with a junk valid bit that must be discarded), then
   // streams bits 0..nbits-1 of f. cfg_last marks bit last_pos (-1: never).
   // gap is the percentage chance of idling cfg_valid in any cycle.
   // Returns the cycle count relative to the cfg_start cycle.
   task automatic stream(input logic [65:0] f, input int nbits, input int last_pos,
                         input int gap, output int cycles);
      int  k;
      bit  v;
      cfg_if.cfg_start = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_bit   = ~f[0];
      cfg_if.cfg_last  = 1'b0;
      tick();
      cfg_if.cfg_start = 1'b0;
      cycles = 1;
      k = 0;
      while (k < nbits && cycles < 3000) begin
         chk("ready_in_shift", {65'd0, cfg_if.cfg_ready}, 66'd1);
         v = ($urandom_range(0, 99) >= gap);
         cfg_if.cfg_valid = v;
         cfg_if.cfg_bit   = v ? f[k] : $urandom_range(0, 1);
         cfg_if.cfg_last  = v && (k == last_pos);
         tick();
         cycles++;
         if (v) k++;
      end
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_last  = 1'b0;
      cfg_if.cfg_bit   = 1'b0;
      if (cycles >= 3000) chk("stream_timeout", 66'(k), 66'(nbits));
   endtask

   task automatic good_frame(input logic [65:0] f, input int gap, input string tag);
      int cyc;
      stream(f, 66, 65, gap, cyc);
      chk({tag, "_done"}, {65'd0, cfg_if.cfg_done}, 66'd1);
      ref_frame = f;
      chk_lut(tag);
      if (gap == 0) chk({tag, "_cycle"}, 66'(cyc), 66'd67);
      tick();
      chk({tag, "_done_pulse"}, {65'd0, cfg_if.cfg_done}, 66'd0);
      chk({tag, "_ready_after"}, {65'd0, cfg_if.cfg_ready}, 66'd0);
   endtask

   task automatic readback(input string tag);
      int bad;
      bad = 0;
      cfg_if.rb_req = 1'b1;
      tick();
      cfg_if.rb_req = 1'b0;
      for (int k = 0; k < 66; k++) begin
         if (cfg_if.rb_valid !== 1'b1 || cfg_if.rb_bit !== ref_frame[k]) bad++;
         tick();
      end
      chk({tag, "_rb_bad_bits"}, 66'(bad), 66'd0);
      chk({tag, "_rb_valid_end"}, {65'd0, cfg_if.rb_valid}, 66'd0);
   endtask

   initial begin
      int          cyc;
      logic [65:0] f;

      prog_rst_n       = 1'b0;
      cfg_if.cfg_start = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_bit   = 1'b0;
      cfg_if.cfg_last  = 1'b0;
      cfg_if.rb_req    = 1'b0;
      ref_frame        = '0;
      #1;
      chk_lut("reset");
      chk("reset_ready", {65'd0, cfg_if.cfg_ready}, 66'd0);
      chk("reset_done", {65'd0, cfg_if.cfg_done}, 66'd0);
      chk("reset_err", {65'd0, cfg_if.cfg_err}, 66'd0);
      chk("reset_rb_valid", {65'd0, cfg_if.rb_valid}, 66'd0);
      tick();
      tick();
      prog_rst_n = 1'b1;
      tick();

      good_frame({2'b10, 64'h8000_0000_0000_0001}, 0, "corner");
      chk("corner_sram0", {65'd0, sram[0]}, 66'd1);
      chk("corner_sram63", {65'd0, sram[63]}, 66'd1);
      readback("corner");

      // Early cfg_last on bit 40.
      stream({$urandom, $urandom, 2'b11}, 41, 40, 0, cyc);
      chk("early_err", {65'd0, cfg_if.cfg_err}, 66'd1);
      chk_lut("early_keep");
      tick();
      chk("early_err_sticky", {65'd0, cfg_if.cfg_err}, 66'd1);
      cfg_if.cfg_start = 1'b1;
      tick();
      cfg_if.cfg_start = 1'b0;
      chk("early_err_clear", {65'd0, cfg_if.cfg_err}, 66'd0);
      chk("early_restart_ready", {65'd0, cfg_if.cfg_ready}, 66'd1);

      // Missing cfg_last on bit 65 (restarts from the SHIFT state).
      stream({$urandom, $urandom, 2'b01}, 66, -1, 0, cyc);
      chk("nolast_err", {65'd0, cfg_if.cfg_err}, 66'd1);
      chk("nolast_done", {65'd0, cfg_if.cfg_done}, 66'd0);
      chk_lut("nolast_keep");

      good_frame({2'b01, 64'hDEAD_BEEF_0123_4567}, 40, "gappy");
      readback("gappy");

      // Abort a frame partway: stream 20 bits, then restart via cfg_start.
      stream({$urandom, $urandom, 2'b10}, 20, -1, 0, cyc);
      good_frame({2'b11, $urandom, $urandom}, 0, "abort");

      // Readback aborted by cfg_start, then a full frame.
      cfg_if.rb_req = 1'b1;
      tick();
      cfg_if.rb_req = 1'b0;
      tick();
      tick();
      chk("rb_midway_valid", {65'd0, cfg_if.rb_valid}, 66'd1);
      f = {2'(2'($urandom)), $urandom, $urandom};
      good_frame(f, 25, "rbabort");
      readback("rbabort");

      // Reset mid-frame at bit 30, asserted between clock edges.
      stream({$urandom, $urandom, 2'b11}, 30, -1, 0, cyc);
      #2;
      prog_rst_n = 1'b0;
      #1;
      ref_frame = '0;
      chk_lut("midrst");
      chk("midrst_ready", {65'd0, cfg_if.cfg_ready}, 66'd0);
      chk("midrst_err", {65'd0, cfg_if.cfg_err}, 66'd0);
      tick();
      prog_rst_n = 1'b1;
      tick();
      good_frame({2'b10, $urandom, $urandom}, 10, "post_rst");

      for (int n = 0; n < 3; n++) begin
         f = {2'(2'($urandom)), $urandom, $urandom};
         good_frame(f, 30, "rand");
         readback("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frac_lut6_cfg_loader.md
# frac_lut6_cfg_loader

Configuration writer for one fracturable 6-input LUT. It accepts a bit-serial configuration frame over a valid/ready handshake and assembles it in a shadow register. On a complete frame it atomically commits the 64 truth-table bits and 2 mode bits to the LUT's `sram`/`sram_inv`/`mode`/`mode_inv` inputs. It sits between the tile's programming chain and the `frac_lut6` instance, and also supports serial readback of the committed configuration.

## Interface
Parameters:
- `SRAM_BITS`, 64: truth-table bits (2^6).
- `MODE_BITS`, 2: fracturing mode bits.
- `FRAME_BITS`, `SRAM_BITS+MODE_BITS` (66): bits per frame. Derived; not overridden.

Ports:
- `prog_clk` in 1: programming clock. One clock; all state is on its rising edge.
- `prog_rst_n` in 1: reset, asynchronous, active-low.
- `cfg_start` in 1: single-cycle pulse; opens a new frame.
- `cfg_valid` in 1: `cfg_bit` is valid.
- `cfg_bit` in 1: serial configuration bit.
- `cfg_last` in 1: qualifies the final bit of the frame.
- `cfg_ready` out 1: loader accepts a bit this cycle.
- `sram` out 64: committed truth table, drives LUT `sram[0:63]`.
- `sram_inv` out 64: always the bitwise inverse of `sram`.
- `mode` out 2: committed mode.
- `mode_inv` out 2: always the bitwise inverse of `mode`.
- `cfg_done` out 1: one-cycle pulse on commit.
- `cfg_err` out 1: sticky framing error.
- `rb_req` in 1: readback request pulse.
- `rb_valid` out 1: readback bit valid.
- `rb_bit` out 1: readback serial data.

## Operation
- States: IDLE, SHIFT, COMMIT, READ, ERR. A 7-bit counter `idx` runs 0..65.
- IDLE:
  - `cfg_ready`=0.
  - `cfg_start` → SHIFT, `idx`=0, `cfg_err` cleared.
  - `rb_req` without `cfg_start` → READ, `idx`=0.
  - `cfg_start` has priority over `rb_req`.
- SHIFT:
  - `cfg_ready`=1. Each accepted bit (`cfg_valid`&`cfg_ready`) is written to `shadow[idx]` and `idx` increments.
  - Bit map: frame bit k<64 → `sram[k]`; frame bit 64 → `mode[0]`; frame bit 65 → `mode[1]`.
  - Accepted bit with `cfg_last`=1 and `idx`=65 → COMMIT.
  - Accepted bit with `cfg_last`=1 and `idx`<65 → ERR.
  - Accepted bit with `cfg_last`=0 and `idx`=65 → ERR.
  - `cfg_start` in SHIFT aborts the frame and restarts at `idx`=0, still in SHIFT. The bit presented in that cycle is discarded.
- COMMIT: one cycle. `shadow` is copied to the `sram`/`mode` registers, `cfg_done`=1, then → IDLE.
- ERR:
  - `cfg_err`=1 and stays set until the next `cfg_start`.
  - Committed outputs are never modified by an errored frame.
  - `cfg_start` → SHIFT.
- READ:
  - Each cycle, `rb_valid`=1 and `rb_bit`=committed frame bit `idx`, in the same bit map as the write path.
  - No backpressure.
  - After `idx`=65 → IDLE.
  - `cfg_start` during READ aborts readback → SHIFT.
- `sram_inv` and `mode_inv` are combinational inverses of the registered outputs, so they are never inconsistent with `sram`/`mode`.

## Timing
- Reset values, asynchronous on `prog_rst_n`=0:
  - state IDLE, `idx`=0, shadow 0.
  - `sram`=0, `sram_inv`=all 1s, `mode`=0, `mode_inv`=2'b11.
  - `cfg_ready`=0, `cfg_done`=0, `cfg_err`=0, `rb_valid`=0, `rb_bit`=0.
- Minimum frame duration:
  - `cfg_start` at cycle 0.
  - Bits accepted in cycles 1..66, one per cycle with `cfg_valid` held high.
  - COMMIT in cycle 67, with `cfg_done` high in that cycle.
  - `sram`/`mode` show new values from cycle 67.
- Gaps in `cfg_valid` stall the frame indefinitely; there is no timeout.
- Readback: `rb_req` at cycle 0; bits 0..65 appear in cycles 1..66.
- `cfg_ready`, `cfg_done` and `rb_valid` are registered outputs. `cfg_ready` depends on state only, never on `cfg_valid`.
- Reset mid-frame: the partial frame is lost and outputs return to their reset values.

## Structure
- Shared package `frac_lut_cfg_pkg`:
  - `SRAM_BITS`, `MODE_BITS`, `FRAME_BITS`.
  - State enum `cfg_state_t`.
  - Bit-index constants `MODE0_IDX`=64 and `MODE1_IDX`=65.
- One natural sub-module: `cfg_frame_shadow`, which holds the 66-bit shadow register, the indexed write, and the commit copy. The FSM, counter and readback mux stay in the top level.

## Test plan
- Reset → `sram`=0, `sram_inv`=64'hFFFF_FFFF_FFFF_FFFF, `mode_inv`=2'b11, `cfg_ready`=0.
- Frame with `sram`=64'h8000_0000_0000_0001 (bit0=1, bit63=1) and `mode`=2'b10, streamed back-to-back → `cfg_done` pulse exactly at cycle 67, `sram[0]`=`sram[63]`=1, `mode`=2'b10, `mode_inv`=2'b01.
- `cfg_last` asserted on bit 40 → `cfg_err`=1, `sram`/`mode` keep their previous values. A following `cfg_start` clears `cfg_err`.
- Random `cfg_valid` gaps over a 66-bit frame of 64'hDEAD_BEEF_0123_4567 with `mode`=2'b01 → committed value matches exactly; `cfg_ready` holds 1 throughout SHIFT.
- `rb_req` after a commit → 66 consecutive `rb_valid` cycles whose bits reproduce the written frame in order.
- `prog_rst_n` pulsed low at bit 30 of a frame → all outputs return to their reset values immediately, without waiting for a clock edge. A fresh frame then commits correctly.
